mod_cu: RTL and testbench

MOD_CU -- requirements
Module: mod_cu

---
 rtl/mod_pkg.sv | 20 ++
 rtl/mod_dp.sv | 17 +
 rtl/mod_top.sv | 46 ++++
 rtl/mod_cu.sv | 124 ++++++++++++
 tb/tb_mod_cu.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mod_pkg.sv
// Shared width constant, state encoding and operand screening for the
// mod_cu / mod_dp repeated-subtraction divider pair.
package mod_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SUB   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Operands must be non-negative and the divisor non-zero.
   function automatic logic bad_operands(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
      return (b == '0) || a[WIDTH-1] || b[WIDTH-1];
   endfunction

endpackage

// File: rtl/mod_dp.sv
// Subtract datapath: temp = a - b, lt flags (a - b) - b as negative.
module mod_dp #(
   parameter int WIDTH = mod_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] temp,
   output logic             lt
);

   logic [WIDTH-1:0] diff2;

   assign temp  = a - b;
   assign diff2 = temp - b;
   assign lt    = diff2[WIDTH-1];

endmodule

// File: rtl/mod_top.sv
// Pairs the mod_cu control unit with its mod_dp subtract datapath.
module mod_top #(
   parameter int WIDTH = mod_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] quotient,
   output logic             err
);

   logic [WIDTH-1:0] dp_a;
   logic [WIDTH-1:0] dp_b;
   logic [WIDTH-1:0] temp;
   logic             lt;

   mod_cu #(.WIDTH(WIDTH)) u_cu (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .lt       (lt),
      .temp     (temp),
      .dp_a     (dp_a),
      .dp_b     (dp_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .quotient (quotient),
      .err      (err)
   );

   mod_dp #(.WIDTH(WIDTH)) u_dp (
      .a    (dp_a),
      .b    (dp_b),
      .temp (temp),
      .lt   (lt)
   );

endmodule

// File: rtl/mod_cu.sv
// Control unit for a modulo/divide-by-repeated-subtraction engine; drives the
// external subtract datapath and registers remainder, quotient and error flag.
module mod_cu #(
   parameter int WIDTH = mod_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             lt,
   input  logic [WIDTH-1:0] temp,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] quotient,
   output logic             err
);

   import mod_pkg::state_t;
   import mod_pkg::IDLE;
   import mod_pkg::CHECK;
   import mod_pkg::SUB;
   import mod_pkg::DONE;
   import mod_pkg::bad_operands;

   state_t           state_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] div_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             busy_reg;
   logic             done_reg;
   logic             err_reg;
   logic [WIDTH-1:0] result_reg;
   logic [WIDTH-1:0] quot_reg;

   // The only adder owned by this block; shared by the counter and quotient load.
   assign cnt_next = cnt_reg + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rem_reg    <= '0;
         div_reg    <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
         result_reg <= '0;
         quot_reg   <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rem_reg  <= a_in;
                  div_reg  <= b_in;
                  cnt_reg  <= '0;
                  busy_reg <= 1'b1;
                  quot_reg <= '0;
                  if (bad_operands(a_in, b_in)) begin
                     err_reg    <= 1'b1;
                     result_reg <= a_in;
                     state_reg  <= DONE;
                  end else begin
                     err_reg    <= 1'b0;
                     result_reg <= '0;
                     state_reg  <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (temp[WIDTH-1]) begin
                  result_reg <= rem_reg;
                  quot_reg   <= '0;
                  state_reg  <= DONE;
               end else begin
                  state_reg <= SUB;
               end
            end
            SUB: begin
               rem_reg <= temp;
               cnt_reg <= cnt_next;
               // lt looks one subtraction ahead, so temp is already the final remainder.
               if (lt) begin
                  result_reg <= temp;
                  quot_reg   <= cnt_next;
                  state_reg  <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign dp_a     = rem_reg;
   assign dp_b     = div_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign result   = result_reg;
   assign quotient = quot_reg;
   assign err      = err_reg;

   busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
      busy_reg == (state_reg != IDLE));

   done_only_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
      done_reg |-> (state_reg == IDLE));

   done_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
      done_reg |=> !done_reg);

endmodule

// File: tb/tb_mod_cu.sv
// Self-checking bench for mod_cu wired to mod_dp: vector table plus reset and
// held-start sequences, results checked through an expectation queue.
module tb_mod_cu;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] quo;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [31:0] quo;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic [31:0] dp_a, dp_b, temp, result, quotient;
   logic        lt, busy, done, err;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   done_cnt = 0;
   logic busy_q = 1'b0;
   logic done_q = 1'b0;
   logic [31:0] t2;
   exp_t e;
   exp_t sb[$];
   vec_t tbl[12];

   mod_cu u_cu (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .lt       (lt),
      .temp     (temp),
      .dp_a     (dp_a),
      .dp_b     (dp_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .quotient (quotient),
      .err      (err)
   );

   mod_dp u_dp (
      .a    (dp_a),
      .b    (dp_b),
      .temp (temp),
      .lt   (lt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst_n) begin
         if (busy && !busy_q) accept_cyc = cyc;
         if (busy) begin
            t2 = dp_a - dp_b - dp_b;
            chk("dp_temp", temp, dp_a - dp_b);
            chk("dp_lt", 32'(lt), 32'(t2[31]));
         end
         if (done) begin
            done_cnt++;
            chk("done_width", 32'(done_q), 32'd0);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               $display("op done: result=%0h quotient=%0h err=%0b latency=%0d", result, quotient, err, cyc - accept_cyc);
               chk("result", result, e.res);
               chk("quotient", quotient, e.quo);
               chk("err", 32'(err), 32'(e.err));
               chk("latency", 32'(cyc - accept_cyc), 32'(e.lat));
            end
         end
      end
      busy_q = busy;
      done_q = done;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_result"}, result, 32'd0);
      chk({tag, "_quotient"}, quotient, 32'd0);
      chk({tag, "_dp_a"}, dp_a, 32'd0);
      chk({tag, "_dp_b"}, dp_b, 32'd0);
   endtask

   initial begin
      int saved;
      tbl[0]  = '{32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 5};
      tbl[1]  = '{32'd3, 32'd8, 32'd3, 32'd0, 1'b0, 2};
      tbl[2]  = '{32'd20, 32'd20, 32'd0, 32'd1, 1'b0, 3};
      tbl[3]  = '{32'd9, 32'd0, 32'd9, 32'd0, 1'b1, 1};
      tbl[4]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 2};
      tbl[5]  = '{32'h8000_0000, 32'd3, 32'h8000_0000, 32'd0, 1'b1, 1};
      tbl[6]  = '{32'd5, 32'h8000_0001, 32'd5, 32'd0, 1'b1, 1};
      tbl[7]  = '{32'd100, 32'd9, 32'd1, 32'd11, 1'b0, 13};
      tbl[8]  = '{32'd64, 32'd1, 32'd0, 32'd64, 1'b0, 66};
      tbl[9]  = '{32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 5};
      tbl[10] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1};
      tbl[11] = '{32'h7FFF_FFFF, 32'h4000_0000, 32'h3FFF_FFFF, 32'd1, 1'b0, 3};

      // Reset state
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         sb.push_back('{tbl[i].res, tbl[i].quo, tbl[i].err, tbl[i].lat});
         issue(tbl[i].a, tbl[i].b);
         wait_drain($sformatf("vec%0d", i));
      end

      // Outputs hold after completion
      repeat (3) @(negedge clk);
      chk("hold_result", result, 32'h3FFF_FFFF);
      chk("hold_quotient", quotient, 32'd1);

      // Reset mid-operation: abandon with no done, then restart immediately
      issue(32'd1000, 32'd7);
      repeat (50) @(posedge clk);
      #2 rst_n = 1'b0;
      saved = done_cnt;
      #1 chk_all_zero("midreset");
      repeat (3) @(negedge clk);
      chk("midreset_no_done", 32'(done_cnt), 32'(saved));
      rst_n = 1'b1;
      a_in  = 32'd10;
      b_in  = 32'd3;
      start = 1'b1;
      sb.push_back('{32'd1, 32'd3, 1'b0, 5});
      @(negedge clk);
      start = 1'b0;
      wait_drain("after_reset");

      // Start held through busy: in-flight op unaffected, second starts after DONE
      @(negedge clk);
      a_in  = 32'd100;
      b_in  = 32'd9;
      start = 1'b1;
      sb.push_back('{32'd1, 32'd11, 1'b0, 13});
      sb.push_back('{32'd1, 32'd7, 1'b0, 9});
      @(negedge clk);
      a_in = 32'd50;
      b_in = 32'd7;
      for (int n = 0; n < 200 && sb.size() > 1; n++) @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_drain("held_start");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
